// File: rtl/obj_table_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// obj_table_pkg : object word layout, shape/op codes, FSM states
// Rev 1.0
// ------------------------------------------------------------------
package obj_table_pkg;

  localparam int OBJ_BITS    = 66;
  localparam int MAX_ENTRIES = 16;
  localparam int LEN_W       = 6;

  // Object word field positions
  localparam int SHAPE_LSB  = 62;
  localparam int X_LSB      = 52;
  localparam int Y_LSB      = 42;
  localparam int WIDTH_LSB  = 32;
  localparam int HEIGHT_LSB = 22;
  localparam int RADIUS_LSB = 12;
  localparam int COLOR_LSB  = 0;

  localparam logic [11:0] COLOR_BLACK = 12'h000;
  localparam logic [11:0] COLOR_WHITE = 12'hfff;
  localparam logic [11:0] COLOR_RED   = 12'hf00;
  localparam logic [11:0] COLOR_GREEN = 12'h0f0;
  localparam logic [11:0] COLOR_BLUE  = 12'h00f;

  typedef enum logic [3:0] {
    SHAPE_NONE      = 4'd0,
    SHAPE_RECTANGLE = 4'd1,
    SHAPE_CIRCLE    = 4'd2,
    SHAPE_ROUNDRECT = 4'd3
  } shape_e;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_CLEAR  = 2'd1,
    OP_COMMIT = 2'd2,
    OP_NOP    = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CLEAR      = 2'd1,
    ST_WAIT_FRAME = 2'd2
  } state_e;

  function automatic logic [OBJ_BITS-1:0] pack_obj(
    input shape_e      shape,
    input logic [9:0]  x,
    input logic [9:0]  y,
    input logic [9:0]  w,
    input logic [9:0]  h,
    input logic [9:0]  r,
    input logic [11:0] colour
  );
    return {shape, x, y, w, h, r, colour};
  endfunction

endpackage
`default_nettype wire

// File: rtl/obj_table_if.sv
`default_nettype none
// ------------------------------------------------------------------
// obj_table_if : command bus (valid/ready plus error pulse)
// Rev 1.0
// ------------------------------------------------------------------
interface obj_table_if #(
  parameter int OBJ_WIDTH = 66,
  parameter int LEN_BITS  = 6
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [LEN_BITS-1:0]  cmd_idx;
  logic [OBJ_WIDTH-1:0] cmd_obj;
  logic                 err;

  modport master (
    output cmd_valid, cmd_op, cmd_idx, cmd_obj,
    input  cmd_ready, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_idx, cmd_obj,
    output cmd_ready, err
  );
endinterface
`default_nettype wire

// File: rtl/vsync_fall_sync.sv
`default_nettype none
// ------------------------------------------------------------------
// vsync_fall_sync : 2-flop synchronizer with falling-edge pulse
// Rev 1.0
// ------------------------------------------------------------------
module vsync_fall_sync (
  input  logic clk,
  input  logic rst,
  input  logic vsync_in,
  output logic fall
);
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = vsync_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Reset high so a low vsync at reset release is not seen as a fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign fall = prev_q & ~sync2_q;
endmodule
`default_nettype wire

// File: rtl/obj_table.sv
`default_nettype none
// ------------------------------------------------------------------
// obj_table : double-buffered object table, live copy on vsync fall
// Rev 1.0
// ------------------------------------------------------------------
module obj_table
  import obj_table_pkg::*;
#(
  parameter int OBJ_WIDTH = OBJ_BITS,
  parameter int MAX_LEN   = MAX_ENTRIES,
  parameter int LEN_BITS  = LEN_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           vsync,
  obj_table_if.slave                     cmd,
  output logic [OBJ_WIDTH*MAX_LEN-1:0]   obj_arr_packed,
  output logic [LEN_BITS-1:0]            arr_len,
  output logic                           commit_done
);
  localparam int                  IDX_W    = $clog2(MAX_LEN);
  localparam logic [LEN_BITS-1:0] LEN_MAX  = LEN_BITS'(MAX_LEN);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(MAX_LEN - 1);

  state_e                         state_q, state_d;
  logic [OBJ_WIDTH-1:0]           shadow_q [MAX_LEN];
  logic [OBJ_WIDTH-1:0]           shadow_d [MAX_LEN];
  logic [LEN_BITS-1:0]            shadow_len_q, shadow_len_d;
  logic [LEN_BITS-1:0]            arr_len_q, arr_len_d;
  logic [IDX_W-1:0]               clr_cnt_q, clr_cnt_d;
  logic [OBJ_WIDTH*MAX_LEN-1:0]   live_q, live_d;
  logic [OBJ_WIDTH*MAX_LEN-1:0]   shadow_flat;
  logic                           done_q, done_d;
  logic                           err_q, err_d;
  logic                           vs_fall;
  logic [LEN_BITS-1:0]            idx_plus1;

  vsync_fall_sync u_vsync (
    .clk      (clk),
    .rst      (rst),
    .vsync_in (vsync),
    .fall     (vs_fall)
  );

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_flat
    assign shadow_flat[i*OBJ_WIDTH +: OBJ_WIDTH] = shadow_q[i];
  end

  assign idx_plus1 = cmd.cmd_idx + LEN_BITS'(1);

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    shadow_len_d = shadow_len_q;
    arr_len_d    = arr_len_q;
    clr_cnt_d    = clr_cnt_q;
    live_d       = live_q;
    done_d       = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          case (cmd_op_e'(cmd.cmd_op))
            OP_WRITE: begin
              if (cmd.cmd_idx < LEN_MAX) begin
                shadow_d[cmd.cmd_idx[IDX_W-1:0]] = cmd.cmd_obj;
                if (idx_plus1 > shadow_len_q) begin
                  shadow_len_d = idx_plus1;
                end
              end else begin
                err_d = 1'b1;
              end
            end
            OP_CLEAR: begin
              clr_cnt_d = '0;
              state_d   = ST_CLEAR;
            end
            OP_COMMIT: state_d = ST_WAIT_FRAME;
            default: ;
          endcase
        end
      end

      ST_CLEAR: begin
        shadow_d[clr_cnt_q] = '0;
        clr_cnt_d           = clr_cnt_q + IDX_W'(1);
        if (clr_cnt_q == LAST_IDX) begin
          shadow_len_d = '0;
          state_d      = ST_IDLE;
        end
      end

      // Only a fall seen after the commit was accepted is used
      ST_WAIT_FRAME: begin
        if (vs_fall) begin
          live_d    = shadow_flat;
          arr_len_d = shadow_len_q;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      for (int i = 0; i < MAX_LEN; i++) begin
        shadow_q[i] <= '0;
      end
      shadow_len_q <= '0;
      arr_len_q    <= '0;
      clr_cnt_q    <= '0;
      live_q       <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      shadow_len_q <= shadow_len_d;
      arr_len_q    <= arr_len_d;
      clr_cnt_q    <= clr_cnt_d;
      live_q       <= live_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign cmd.cmd_ready  = (state_q == ST_IDLE);
  assign cmd.err        = err_q;
  assign obj_arr_packed = live_q;
  assign arr_len        = arr_len_q;
  assign commit_done    = done_q;
endmodule
`default_nettype wire

// File: tb/tb_obj_table.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_obj_table : directed bench with per-cycle reference model
// Rev 1.0
// ------------------------------------------------------------------
module tb_obj_table;
  import obj_table_pkg::*;

  localparam int W  = 66;
  localparam int N  = 16;
  localparam int LB = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             vsync = 1'b1;
  logic [W*N-1:0]   obj_arr_packed;
  logic [LB-1:0]    arr_len;
  logic             commit_done;

  int checks = 0;
  int errors = 0;
  int done_count = 0;

  obj_table_if #(.OBJ_WIDTH(W), .LEN_BITS(LB)) bus ();

  obj_table #(.OBJ_WIDTH(W), .MAX_LEN(N), .LEN_BITS(LB)) dut (
    .clk            (clk),
    .rst            (rst),
    .vsync          (vsync),
    .cmd            (bus.slave),
    .obj_arr_packed (obj_arr_packed),
    .arr_len        (arr_len),
    .commit_done    (commit_done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [W-1:0] m_shadow [N];
  logic [W-1:0] m_live   [N];
  int           m_len, m_live_len, m_busy;
  bit           m_wait, m_done, m_err;
  bit           v1, v2, v3;

  initial begin
    bit fall;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < N; i++) begin
          m_shadow[i] = '0;
          m_live[i]   = '0;
        end
        m_len = 0; m_live_len = 0; m_busy = 0;
        m_wait = 0; m_done = 0; m_err = 0;
        v1 = 1; v2 = 1; v3 = 1;
      end else begin
        // a fall first sampled two edges ago becomes visible now
        fall   = (v2 == 1'b0) && (v3 == 1'b1);
        m_done = 0;
        m_err  = 0;
        if (m_busy > 0) begin
          m_busy--;
          if (m_busy == 0) begin
            for (int i = 0; i < N; i++) m_shadow[i] = '0;
            m_len = 0;
          end
        end else if (m_wait) begin
          if (fall) begin
            for (int i = 0; i < N; i++) m_live[i] = m_shadow[i];
            m_live_len = m_len;
            m_done     = 1;
            m_wait     = 0;
          end
        end else if (bus.cmd_valid) begin
          case (bus.cmd_op)
            2'd0: begin
              if (int'(bus.cmd_idx) < N) begin
                m_shadow[bus.cmd_idx] = bus.cmd_obj;
                if (int'(bus.cmd_idx) + 1 > m_len) m_len = int'(bus.cmd_idx) + 1;
              end else begin
                m_err = 1;
              end
            end
            2'd1: m_busy = N;
            2'd2: m_wait = 1;
            default: ;
          endcase
        end
        v3 = v2; v2 = v1; v1 = vsync;
      end
    end
  end

  // ---------------- comparison helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_arr(input string name, input logic [W*N-1:0] act, input logic [W*N-1:0] exp);
    bit shown;
    checks++;
    if (act !== exp) begin
      errors++;
      shown = 0;
      for (int i = 0; i < N; i++) begin
        if (!shown && act[i*W +: W] !== exp[i*W +: W]) begin
          $display("FAIL %s entry %0d: got %h expected %h", name, i, act[i*W +: W], exp[i*W +: W]);
          shown = 1;
        end
      end
    end
  endtask

  initial begin
    logic [W*N-1:0] exp_arr;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < N; i++) exp_arr[i*W +: W] = m_live[i];
        check("cmd_ready", 64'(bus.cmd_ready), 64'((m_busy == 0) && !m_wait));
        check("arr_len", 64'(arr_len), 64'(m_live_len));
        check("commit_done", 64'(commit_done), 64'(m_done));
        check("err", 64'(bus.err), 64'(m_err));
        check_arr("obj_arr_packed", obj_arr_packed, exp_arr);
        if (commit_done) done_count++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [1:0] op, input logic [LB-1:0] idx, input logic [W-1:0] obj);
    bit ok;
    ok = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_idx   = idx;
    bus.cmd_obj   = obj;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (bus.cmd_ready) ok = 1;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd3;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 within 200 cycles");
    end
  endtask

  task automatic vsync_pulse(input int n);
    vsync = 1'b0;
    idle(n);
    vsync = 1'b1;
  endtask

  initial begin
    logic [W-1:0] obj_a, obj_b, obj_c;
    int           low_cycles, dc0;
    obj_a = {4'd1, 10'd100, 10'd100, 10'd100, 10'd100, 10'd0, 12'h0f0};
    obj_b = pack_obj(SHAPE_CIRCLE, 10'd320, 10'd240, 10'd0, 10'd0, 10'd50, COLOR_RED);
    obj_c = pack_obj(SHAPE_ROUNDRECT, 10'd10, 10'd20, 10'd30, 10'd40, 10'd5, COLOR_BLUE);

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd3;
    bus.cmd_idx   = '0;
    bus.cmd_obj   = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_ready", 64'(bus.cmd_ready), 64'd1);
    check("reset_len", 64'(arr_len), 64'd0);
    check_arr("reset_arr", obj_arr_packed, '0);

    // write only touches the shadow until a commit and a frame edge
    send(2'd0, 6'd0, obj_a);
    idle(5);
    check("write_no_live_len", 64'(arr_len), 64'd0);
    check_arr("write_no_live_arr", obj_arr_packed, '0);
    send(2'd2, 6'd0, '0);
    idle(10);
    check("commit_wait_len", 64'(arr_len), 64'd0);
    vsync_pulse(20);
    idle(5);
    check("commit1_len", 64'(arr_len), 64'd1);
    check("commit1_entry0", obj_arr_packed[63:0], obj_a[63:0]);
    check("commit1_entry0_hi", 64'(obj_arr_packed[W-1:64]), 64'(obj_a[W-1:64]));

    // commit latency measured from the first edge sampling vsync low
    send(2'd0, 6'd3, obj_b);
    send(2'd2, 6'd0, '0);
    idle(50);
    vsync = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("lat_done_e1", 64'(commit_done), 64'd0);
    @(posedge clk);
    #1;
    check("lat_done_e2", 64'(commit_done), 64'd1);
    check("lat_len_e2", 64'(arr_len), 64'd4);
    @(negedge clk);
    idle(10);
    vsync = 1'b1;
    idle(10);

    // commit during low vsync waits for the next fall
    vsync = 1'b0;
    idle(5);
    send(2'd0, 6'd1, obj_c);
    send(2'd2, 6'd0, '0);
    idle(10);
    check("low_commit_entry1", 64'(obj_arr_packed[2*W-1:W] == '0), 64'd1);
    vsync = 1'b1;
    idle(10);
    vsync = 1'b0;
    idle(6);
    check("next_fall_entry1", obj_arr_packed[W +: 64], obj_c[63:0]);
    check("next_fall_len", 64'(arr_len), 64'd4);
    vsync = 1'b1;
    idle(5);

    // clear: ready low for exactly N cycles
    send(2'd1, 6'd0, '0);
    low_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      if (!bus.cmd_ready) low_cycles++;
      @(negedge clk);
    end
    check("clear_busy_cycles", 64'(low_cycles), 64'd16);
    send(2'd2, 6'd0, '0);
    vsync_pulse(10);
    idle(5);
    check("clear_commit_len", 64'(arr_len), 64'd0);
    check_arr("clear_commit_arr", obj_arr_packed, '0);

    // out-of-range write
    send(2'd0, 6'd16, obj_b);
    check("err_pulse", 64'(bus.err), 64'd1);
    idle(1);
    check("err_drop", 64'(bus.err), 64'd0);
    send(2'd2, 6'd0, '0);
    vsync_pulse(10);
    idle(5);
    check("err_commit_len", 64'(arr_len), 64'd0);
    check_arr("err_commit_arr", obj_arr_packed, '0);

    // reset drops a pending commit
    dc0 = done_count;
    send(2'd0, 6'd0, obj_a);
    send(2'd2, 6'd0, '0);
    idle(5);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);
    vsync_pulse(10);
    idle(5);
    check("rst_no_done", 64'(done_count), 64'(dc0));
    check("rst_len", 64'(arr_len), 64'd0);
    check_arr("rst_arr", obj_arr_packed, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
